state_dump_unit: RTL and testbench



---
 rtl/state_dump_unit.sv | 182 ++++++++++++++++++
 tb/tb_state_dump_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
// state_dump_unit
//   Streams a snapshot of processor state as a sequence of records over a
//   valid/ready channel. Each dump is one header record carrying the free-running
//   cycle count, then NUM_REGS register-file records, then MEM_BYTES
//   data-memory records. The final record is flagged with dump_last_o.
//   A dump starts on trig_i. When PERIODIC=1, a dump also starts automatically
//   every PERIOD cycles. A request that arrives while a dump is in progress
//   is discarded and latches dropped_o.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-low reset
//   trig_i               dump request
//   reg_addr_o/data_i    register-file read port (data combinational on addr)
//   mem_addr_o/data_i    data-memory byte read port (data combinational on addr)
//   dump_valid_o/ready_i record handshake
//   dump_kind_o          0 header, 1 register, 2 memory
//   dump_idx_o           register/memory index (0 for header)
//   dump_data_o          record payload
//   dump_last_o          final record of the dump
//   busy_o               dump in progress
//   dropped_o            sticky: a request was discarded while busy
module state_dump_unit #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int MEM_BYTES = 32,
    parameter int PERIODIC  = 0,
    parameter int PERIOD    = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    output logic [7:0]        reg_addr_o,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [7:0]        mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [1:0]        dump_kind_o,
    output logic [7:0]        dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              dropped_o
);

    typedef enum logic [1:0] {IDLE, HDR, REG, MEM} state_t;

    localparam logic [1:0] KIND_HDR = 2'd0;
    localparam logic [1:0] KIND_REG = 2'd1;
    localparam logic [1:0] KIND_MEM = 2'd2;
    localparam logic [7:0] REG_LAST = 8'(NUM_REGS - 1);
    localparam logic [7:0] MEM_LAST = 8'(MEM_BYTES - 1);
    localparam int         PW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(PERIOD - 1);

    state_t            r_state;
    logic [7:0]        r_ptr;      // index of the next register/memory record to load
    logic [31:0]       r_cnt;
    logic [PW-1:0]     r_phase;    // tracks r_cnt mod PERIOD without a divider
    logic              r_valid;
    logic [1:0]        r_kind;
    logic [7:0]        r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic              r_busy;
    logic              r_dropped;

    logic w_xfer;
    logic w_load;
    logic w_auto;
    logic w_req;
    logic w_final;

    assign w_xfer  = r_valid & dump_ready_i;
    assign w_load  = ~r_valid | dump_ready_i;
    assign w_auto  = (PERIODIC != 0) && (r_phase == PHASE_LAST);
    assign w_req   = trig_i | w_auto;
    // r_last is only ever set on the final memory record.
    assign w_final = r_last & w_xfer;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_phase   <= '0;
            r_valid   <= 1'b0;
            r_kind    <= KIND_HDR;
            r_idx     <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_dropped <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            // The phase restarts when the 32-bit count wraps, so it stays equal
            // to the counter modulo PERIOD even across the wrap.
            r_phase <= (r_cnt == '1 || r_phase == PHASE_LAST) ? '0 : r_phase + 1'b1;

            if (w_req && r_busy && !w_final)
                r_dropped <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state <= HDR;
                        r_valid <= 1'b1;
                        r_kind  <= KIND_HDR;
                        r_idx   <= '0;
                        r_data  <= DATA_W'(r_cnt);
                        r_last  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                HDR: begin
                    // Register 0 is loaded as the header leaves; reg_addr_o is
                    // already 0 here, so reg_data_i is the right word.
                    if (w_xfer) begin
                        r_state <= REG;
                        r_kind  <= KIND_REG;
                        r_idx   <= '0;
                        r_data  <= reg_data_i;
                        r_ptr   <= 8'd1;
                    end
                end
                REG: begin
                    if (w_load) begin
                        r_valid <= 1'b1;
                        r_kind  <= KIND_REG;
                        r_idx   <= r_ptr;
                        r_data  <= reg_data_i;
                        if (r_ptr == REG_LAST) begin
                            r_state <= MEM;
                            r_ptr   <= '0;
                        end else begin
                            r_ptr <= r_ptr + 8'd1;
                        end
                    end
                end
                MEM: begin
                    if (w_final) begin
                        if (w_req) begin
                            // Back-to-back dump: header replaces the last record.
                            r_state <= HDR;
                            r_kind  <= KIND_HDR;
                            r_idx   <= '0;
                            r_data  <= DATA_W'(r_cnt);
                            r_last  <= 1'b0;
                            r_ptr   <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_load && !r_last) begin
                        r_valid <= 1'b1;
                        r_kind  <= KIND_MEM;
                        r_idx   <= r_ptr;
                        r_data  <= DATA_W'(mem_data_i);
                        r_last  <= (r_ptr == MEM_LAST);
                        if (r_ptr != MEM_LAST)
                            r_ptr <= r_ptr + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign reg_addr_o   = (r_state == REG) ? r_ptr : 8'd0;
    assign mem_addr_o   = (r_state == MEM) ? r_ptr : 8'd0;
    assign dump_valid_o = r_valid;
    assign dump_kind_o  = r_kind;
    assign dump_idx_o   = r_idx;
    assign dump_data_o  = r_data;
    assign dump_last_o  = r_last;
    assign busy_o       = r_busy;
    assign dropped_o    = r_dropped;

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: a default instance (a) driven through directed
// dumps, two periodic instances (b: PERIOD=100, c: PERIOD=20) and a narrow
// instance (d: NUM_REGS=8, MEM_BYTES=1, DATA_W=16).
module tb_state_dump_unit;
    localparam int NR = 32;
    localparam int MB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc0 = 0;   // cycles since instance a's last reset release
    int cycp = 0;   // cycles since b/c/d reset release

    logic [31:0] regs[256];
    logic [7:0]  mem[256];
    logic [31:0] noise;
    logic [31:0] hb[$];

    // instance a
    logic        rst_a, trig_a, rdy_a, v_a, l_a, b_a, dr_a;
    logic [7:0]  ra_a, ma_a, md_a, i_a;
    logic [31:0] rd_a, d_a;
    logic [1:0]  k_a;
    assign rd_a = regs[ra_a] ^ noise;
    assign md_a = mem[ma_a];

    // shared reset for b/c/d
    logic rst_p;

    logic        v_b, l_b, bz_b, dr_b;
    logic [7:0]  ra_b, ma_b, md_b, i_b;
    logic [31:0] rd_b, d_b;
    logic [1:0]  k_b;
    assign rd_b = regs[ra_b];
    assign md_b = mem[ma_b];

    logic        v_c, l_c, bz_c, dr_c;
    logic [7:0]  ra_c, ma_c, md_c, i_c;
    logic [31:0] rd_c, d_c;
    logic [1:0]  k_c;
    assign rd_c = regs[ra_c];
    assign md_c = mem[ma_c];

    logic        trig_d, v_d, l_d, bz_d, dr_d;
    logic [7:0]  ra_d, ma_d, md_d, i_d;
    logic [15:0] rd_d, d_d;
    logic [1:0]  k_d;
    assign rd_d = regs[ra_d][15:0];
    assign md_d = mem[ma_d];

    logic one = 1'b1;
    logic zero = 1'b0;

    state_dump_unit u_a (
        .clk_i(clk), .rst_i(rst_a), .trig_i(trig_a),
        .reg_addr_o(ra_a), .reg_data_i(rd_a), .mem_addr_o(ma_a), .mem_data_i(md_a),
        .dump_valid_o(v_a), .dump_ready_i(rdy_a), .dump_kind_o(k_a), .dump_idx_o(i_a),
        .dump_data_o(d_a), .dump_last_o(l_a), .busy_o(b_a), .dropped_o(dr_a));

    state_dump_unit #(.PERIODIC(1), .PERIOD(100)) u_b (
        .clk_i(clk), .rst_i(rst_p), .trig_i(zero),
        .reg_addr_o(ra_b), .reg_data_i(rd_b), .mem_addr_o(ma_b), .mem_data_i(md_b),
        .dump_valid_o(v_b), .dump_ready_i(one), .dump_kind_o(k_b), .dump_idx_o(i_b),
        .dump_data_o(d_b), .dump_last_o(l_b), .busy_o(bz_b), .dropped_o(dr_b));

    state_dump_unit #(.PERIODIC(1), .PERIOD(20)) u_c (
        .clk_i(clk), .rst_i(rst_p), .trig_i(zero),
        .reg_addr_o(ra_c), .reg_data_i(rd_c), .mem_addr_o(ma_c), .mem_data_i(md_c),
        .dump_valid_o(v_c), .dump_ready_i(one), .dump_kind_o(k_c), .dump_idx_o(i_c),
        .dump_data_o(d_c), .dump_last_o(l_c), .busy_o(bz_c), .dropped_o(dr_c));

    state_dump_unit #(.DATA_W(16), .NUM_REGS(8), .MEM_BYTES(1)) u_d (
        .clk_i(clk), .rst_i(rst_p), .trig_i(trig_d),
        .reg_addr_o(ra_d), .reg_data_i(rd_d), .mem_addr_o(ma_d), .mem_data_i(md_d),
        .dump_valid_o(v_d), .dump_ready_i(one), .dump_kind_o(k_d), .dump_idx_o(i_d),
        .dump_data_o(d_d), .dump_last_o(l_d), .busy_o(bz_d), .dropped_o(dr_d));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc0++;
        cycp++;
        // b runs with ready tied high, so each header is visible for one cycle.
        if (v_b && k_b == 2'd0 && hb.size() < 3) hb.push_back(d_b);
    endtask

    // Record n of a dump, straight from the dump layout: header, registers, memory.
    function automatic void exp_rec(input int n, input int nr, input int mb,
                                    input logic [31:0] hdr, output logic [1:0] k,
                                    output logic [7:0] ix, output logic [31:0] d,
                                    output logic l);
        if (n == 0) begin
            k = 2'd0; ix = 8'd0; d = hdr;
        end else if (n <= nr) begin
            k = 2'd1; ix = 8'(n - 1); d = regs[n-1];
        end else begin
            k = 2'd2; ix = 8'(n - 1 - nr); d = {24'h0, mem[n-1-nr]};
        end
        l = (n == nr + mb);
    endfunction

    // Walks instance a through one dump whose header is currently presented.
    task automatic collect_a(input logic [31:0] hdr, input bit stall, input int mid_n,
                             input int stop_n, input bit trig_final,
                             output int nrec, output int iters, output logic [31:0] next_hdr);
        logic [1:0]  ek;
        logic [7:0]  ei;
        logic [31:0] ed;
        logic        el;
        logic        held;
        logic [42:0] hv;
        nrec = 0; iters = 0; held = 1'b0; next_hdr = '0; hv = '0;
        while (nrec < 1 + NR + MB && iters < 400) begin
            if (nrec == stop_n) return;
            trig_a = 1'b0;
            rdy_a  = 1'b1;
            noise  = '0;
            if (stall && nrec >= 1 && nrec <= NR) begin
                rdy_a = (iters % 4 == 0) || (iters % 4 == 3);
                if (!rdy_a) noise = $urandom;
            end
            chk($sformatf("a_valid_it%0d", iters), v_a, 1);
            chk($sformatf("a_busy_it%0d", iters), b_a, 1);
            if (held) chk($sformatf("a_hold_rec%0d", nrec), {k_a, i_a, d_a, l_a}, hv);
            if (nrec == mid_n) trig_a = 1'b1;
            if (rdy_a) begin
                exp_rec(nrec, NR, MB, hdr, ek, ei, ed, el);
                chk($sformatf("a_rec%0d_kind", nrec), k_a, ek);
                chk($sformatf("a_rec%0d_idx", nrec), i_a, ei);
                chk($sformatf("a_rec%0d_data", nrec), d_a, ed);
                chk($sformatf("a_rec%0d_last", nrec), l_a, el);
                if (el && trig_final) begin
                    trig_a = 1'b1;
                    next_hdr = cyc0;
                end
                nrec++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hv = {k_a, i_a, d_a, l_a};
            end
            tick();
            iters++;
        end
        trig_a = 1'b0;
        rdy_a  = 1'b1;
        noise  = '0;
        chk("a_dump_len", nrec, 1 + NR + MB);
    endtask

    initial begin
        int          nrec, iters, n;
        logic [31:0] nh, h;
        logic [1:0]  ek;
        logic [7:0]  ei;
        logic [31:0] ed;
        logic        el;

        for (int i = 0; i < 256; i++) begin
            regs[i] = $urandom;
            mem[i]  = 8'($urandom);
        end
        noise = '0; trig_a = 1'b0; trig_d = 1'b0; rdy_a = 1'b1;
        rst_a = 1'b0; rst_p = 1'b0;

        #12;
        chk("rst_valid", v_a, 0); chk("rst_kind", k_a, 0); chk("rst_idx", i_a, 0);
        chk("rst_data", d_a, 0);  chk("rst_last", l_a, 0); chk("rst_busy", b_a, 0);
        chk("rst_dropped", dr_a, 0); chk("rst_raddr", ra_a, 0); chk("rst_maddr", ma_a, 0);
        rst_a = 1'b1; rst_p = 1'b1; cyc0 = 0; cycp = 0;

        // Dump A: trigger at counter 5, ready high, trigger again on the final transfer.
        while (cyc0 < 5) tick();
        chk("idle_valid", v_a, 0);
        chk("idle_busy", b_a, 0);
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        collect_a(32'd5, 1'b0, -1, -1, 1'b1, nrec, iters, nh);
        chk("a_consecutive_valid", iters, 65);
        chk("a_dropped_after_final_trig", dr_a, 0);

        // Dump B: back-to-back, ready pattern 1,0,0,1 in REG, extra request mid-dump.
        collect_a(nh, 1'b1, 10, -1, 1'b0, nrec, iters, h);
        chk("b2b_dropped", dr_a, 1);
        chk("end_valid", v_a, 0);
        chk("end_busy", b_a, 0);
        tick();
        chk("end_valid2", v_a, 0);
        chk("dropped_sticky", dr_a, 1);

        // Dump C: reset asynchronously while presenting memory record 10.
        h = cyc0;
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        collect_a(h, 1'b0, -1, 1 + NR + 10, 1'b0, nrec, iters, nh);
        chk("pre_rst_kind", k_a, 2);
        chk("pre_rst_idx", i_a, 10);
        rst_a = 1'b0;
        #1;
        chk("arst_valid", v_a, 0); chk("arst_kind", k_a, 0); chk("arst_idx", i_a, 0);
        chk("arst_data", d_a, 0);  chk("arst_last", l_a, 0); chk("arst_busy", b_a, 0);
        chk("arst_dropped", dr_a, 0); chk("arst_raddr", ra_a, 0); chk("arst_maddr", ma_a, 0);
        #2;
        rst_a = 1'b1;
        cyc0 = 0;
        tick(); tick();
        chk("post_rst_idle", v_a, 0);
        h = cyc0;
        trig_a = 1'b1;
        tick();
        trig_a = 1'b0;
        collect_a(h, 1'b0, -1, -1, 1'b0, nrec, iters, nh);

        // Narrow instance: run the counter past 16 bits so the header truncates.
        while (cycp < 70000) tick();
        h = cycp & 32'hFFFF;
        trig_d = 1'b1;
        tick();
        trig_d = 1'b0;
        n = 0;
        for (int t = 0; t < 30 && n < 10; t++) begin
            if (v_d) begin
                exp_rec(n, 8, 1, h, ek, ei, ed, el);
                chk($sformatf("d_rec%0d_kind", n), k_d, ek);
                chk($sformatf("d_rec%0d_idx", n), i_d, ei);
                chk($sformatf("d_rec%0d_data", n), d_d, ed[15:0]);
                chk($sformatf("d_rec%0d_last", n), l_d, el);
                n++;
            end
            tick();
        end
        chk("d_dump_len", n, 10);
        chk("d_end_valid", v_d, 0);

        // Periodic instances.
        chk("b_hdr_count", hb.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("b_hdr%0d", i), (i < hb.size()) ? hb[i] : 32'hFFFFFFFF, 99 + 100 * i);
        chk("b_dropped", dr_b, 0);
        chk("c_dropped", dr_c, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
